// File: rtl/rv.sv
// Shared RV32I execute-stage types: ALU op codes, writeback selects, register address type,
// and the branch funct3 encodings.
package rv;
    localparam int XLEN = 32;

    typedef logic [4:0] regaddr_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } aluop_t;

    typedef enum logic [1:0] {
        WSEL_ALU,
        WSEL_MEM,
        WSEL_PC4,
        WSEL_CSR
    } wsel_t;

    typedef enum logic {
        ST_NORMAL,
        ST_SHADOW
    } ex_state_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;
endpackage

// File: rtl/core_execute_if.sv
// Decode-to-execute and execute-to-memory bundles. The execute stage is the slave;
// the surrounding pipeline (decode producer, memory consumer) is the master.
interface core_execute_if;
    import rv::*;

    logic            x_valid;
    logic            x_ready;
    logic [XLEN-1:0] x_pc;
    logic [XLEN-1:0] x_imm;
    logic [XLEN-1:0] x_rs1;
    logic [XLEN-1:0] x_rs2;
    logic [XLEN-1:0] x_csr_value;
    regaddr_t        x_rd;
    logic            x_reg_wen;
    wsel_t           x_reg_wsel;
    aluop_t          x_aluop;
    logic            x_asel;
    logic            x_bsel;
    logic [2:0]      x_mem_type;
    logic            x_mem_ren;
    logic            x_mem_wen;
    logic            x_is_jump;
    logic            x_is_branch;
    logic [2:0]      x_branch_cond;

    logic            m_valid;
    logic            m_ready;
    logic [XLEN-1:0] m_pc;
    logic [XLEN-1:0] m_result;
    logic [XLEN-1:0] m_store_data;
    regaddr_t        m_rd;
    logic            m_reg_wen;
    logic            m_mem_ren;
    logic            m_mem_wen;
    wsel_t           m_reg_wsel;
    logic [2:0]      m_mem_type;

    modport slave (
        input  x_valid, x_pc, x_imm, x_rs1, x_rs2, x_csr_value, x_rd, x_reg_wen, x_reg_wsel,
               x_aluop, x_asel, x_bsel, x_mem_type, x_mem_ren, x_mem_wen, x_is_jump,
               x_is_branch, x_branch_cond, m_ready,
        output x_ready, m_valid, m_pc, m_result, m_store_data, m_rd, m_reg_wen, m_mem_ren,
               m_mem_wen, m_reg_wsel, m_mem_type
    );

    modport master (
        output x_valid, x_pc, x_imm, x_rs1, x_rs2, x_csr_value, x_rd, x_reg_wen, x_reg_wsel,
               x_aluop, x_asel, x_bsel, x_mem_type, x_mem_ren, x_mem_wen, x_is_jump,
               x_is_branch, x_branch_cond, m_ready,
        input  x_ready, m_valid, m_pc, m_result, m_store_data, m_rd, m_reg_wen, m_mem_ren,
               m_mem_wen, m_reg_wsel, m_mem_type
    );
endinterface

// File: rtl/core_alu.sv
// Combinational RV32I ALU plus the branch comparator; sum is always a+b so the
// jump target is available regardless of the selected op.
module core_alu
    import rv::*;
#(
    parameter int XLEN = 32
) (
    input  aluop_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] cmp_a,
    input  logic [XLEN-1:0] cmp_b,
    input  logic [2:0]      cond,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] sum,
    output logic            cond_true
);
    logic [4:0] shamt;

    assign shamt = b[4:0];
    assign sum   = a + b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = sum;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            BR_EQ:   cond_true = (cmp_a == cmp_b);
            BR_NE:   cond_true = (cmp_a != cmp_b);
            BR_LT:   cond_true = ($signed(cmp_a) <  $signed(cmp_b));
            BR_GE:   cond_true = ($signed(cmp_a) >= $signed(cmp_b));
            BR_LTU:  cond_true = (cmp_a <  cmp_b);
            BR_GEU:  cond_true = (cmp_a >= cmp_b);
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/core_execute.sv
// RV32I execute stage: ALU, branch/jump resolution, registered memory-stage bundle,
// and a one-cycle redirect that also squashes the single wrong-path instruction.
//
//   state     | meaning
//   ST_NORMAL | instructions are executed and loaded into the m register
//   ST_SHADOW | redirect_valid pulse; the wrong-path instruction is accepted and dropped
module core_execute
    import rv::*;
#(
    parameter int              XLEN     = rv::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    core_execute_if.slave   bus,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output regaddr_t        fwd_rd,
    output logic            fwd_wen,
    output logic [XLEN-1:0] fwd_value,
    output logic            load_pending
);
    ex_state_t       state, state_nxt;
    logic            shadow;
    logic            fire;
    logic            load_m;
    logic            taken;
    logic            cond_true;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] alu_res, alu_sum;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] target;

    assign shadow      = (state == ST_SHADOW);
    assign bus.x_ready = shadow | ~bus.m_valid | bus.m_ready;
    assign fire        = bus.x_valid & bus.x_ready;
    assign load_m      = fire & ~shadow;

    assign op_a = bus.x_asel ? bus.x_pc  : bus.x_rs1;
    assign op_b = bus.x_bsel ? bus.x_imm : bus.x_rs2;

    core_alu #(.XLEN(XLEN)) u_alu (
        .op        (bus.x_aluop),
        .a         (op_a),
        .b         (op_b),
        .cmp_a     (bus.x_rs1),
        .cmp_b     (bus.x_rs2),
        .cond      (bus.x_branch_cond),
        .result    (alu_res),
        .sum       (alu_sum),
        .cond_true (cond_true)
    );

    assign taken  = bus.x_is_jump | (bus.x_is_branch & cond_true);
    // JAL and JALR both come through the adder; bit 0 is cleared for JALR.
    assign target = bus.x_is_jump ? (alu_sum & ~XLEN'(1)) : (bus.x_pc + bus.x_imm);

    always_comb begin
        result = alu_res;
        case (bus.x_reg_wsel)
            WSEL_PC4: result = bus.x_pc + XLEN'(4);
            WSEL_CSR: result = bus.x_csr_value;
            default:  result = alu_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_NORMAL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_NORMAL: if (fire & taken) state_nxt = ST_SHADOW;
            ST_SHADOW: state_nxt = ST_NORMAL;
            default:   state_nxt = ST_NORMAL;
        endcase
    end

    assign redirect_valid = shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               redirect_pc <= RESET_PC;
        else if (load_m & taken)  redirect_pc <= target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_valid      <= 1'b0;
            bus.m_pc         <= '0;
            bus.m_result     <= '0;
            bus.m_store_data <= '0;
            bus.m_rd         <= '0;
            bus.m_reg_wen    <= 1'b0;
            bus.m_mem_ren    <= 1'b0;
            bus.m_mem_wen    <= 1'b0;
            bus.m_reg_wsel   <= WSEL_ALU;
            bus.m_mem_type   <= '0;
        end else if (load_m) begin
            bus.m_valid      <= 1'b1;
            bus.m_pc         <= bus.x_pc;
            bus.m_result     <= result;
            bus.m_store_data <= bus.x_rs2;
            bus.m_rd         <= bus.x_rd;
            bus.m_reg_wen    <= bus.x_reg_wen;
            bus.m_mem_ren    <= bus.x_mem_ren;
            bus.m_mem_wen    <= bus.x_mem_wen;
            bus.m_reg_wsel   <= bus.x_reg_wsel;
            bus.m_mem_type   <= bus.x_mem_type;
        end else if (bus.m_ready) begin
            bus.m_valid      <= 1'b0;
        end
    end

    assign fwd_rd       = bus.m_rd;
    assign fwd_value    = bus.m_result;
    assign fwd_wen      = bus.m_valid & bus.m_reg_wen & ~bus.m_mem_ren;
    assign load_pending = bus.m_valid & bus.m_mem_ren;
endmodule

// File: tb/tb_core_execute.sv
// Directed bench for core_execute: a transaction-level model of the stage is compared
// against the DUT every cycle, alongside hand-computed literal expectations.
module tb_core_execute;
    import rv::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_execute_if bus();

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    regaddr_t    fwd_rd;
    logic        fwd_wen;
    logic [31:0] fwd_value;
    logic        load_pending;

    core_execute #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fwd_rd         (fwd_rd),
        .fwd_wen        (fwd_wen),
        .fwd_value      (fwd_value),
        .load_pending   (load_pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one entry per accepted instruction) ----------------
    logic        em_valid = 1'b0;
    logic [31:0] em_pc = '0, em_result = '0, em_store = '0;
    regaddr_t    em_rd = '0;
    logic        em_reg_wen = 1'b0, em_mem_ren = 1'b0, em_mem_wen = 1'b0;
    wsel_t       em_wsel = WSEL_ALU;
    logic [2:0]  em_mem_type = '0;
    logic        e_redir = 1'b0;
    logic [31:0] e_redir_pc = RESET_PC;

    function automatic logic [31:0] alu_ref(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLL:   return a << sh;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return 32'($signed(a) >>> sh);
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   return a ^ b;
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_PASSB: return b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                em_valid = 0; em_pc = 0; em_result = 0; em_store = 0; em_rd = 0;
                em_reg_wen = 0; em_mem_ren = 0; em_mem_wen = 0; em_wsel = WSEL_ALU;
                em_mem_type = 0; e_redir = 0; e_redir_pc = RESET_PC;
            end else begin
                logic was_shadow, accept;
                logic [31:0] a, b, r;
                was_shadow = e_redir;
                accept = bus.x_valid && (was_shadow || !em_valid || bus.m_ready);
                e_redir = 0;
                if (accept && !was_shadow) begin
                    a = bus.x_asel ? bus.x_pc : bus.x_rs1;
                    b = bus.x_bsel ? bus.x_imm : bus.x_rs2;
                    if (bus.x_reg_wsel == WSEL_PC4)      r = bus.x_pc + 4;
                    else if (bus.x_reg_wsel == WSEL_CSR) r = bus.x_csr_value;
                    else                                 r = alu_ref(bus.x_aluop, a, b);
                    em_valid = 1; em_pc = bus.x_pc; em_result = r; em_store = bus.x_rs2;
                    em_rd = bus.x_rd; em_reg_wen = bus.x_reg_wen; em_mem_ren = bus.x_mem_ren;
                    em_mem_wen = bus.x_mem_wen; em_wsel = bus.x_reg_wsel; em_mem_type = bus.x_mem_type;
                    if (bus.x_is_jump) begin
                        e_redir = 1; e_redir_pc = (a + b) & 32'hFFFF_FFFE;
                    end else if (bus.x_is_branch && br_ref(bus.x_branch_cond, bus.x_rs1, bus.x_rs2)) begin
                        e_redir = 1; e_redir_pc = bus.x_pc + bus.x_imm;
                    end
                end else if (bus.m_ready) begin
                    em_valid = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("x_ready", 32'(bus.x_ready), 32'(e_redir || !em_valid || bus.m_ready));
            check("m_valid", 32'(bus.m_valid), 32'(em_valid));
            check("redirect_valid", 32'(redirect_valid), 32'(e_redir));
            check("redirect_pc", redirect_pc, e_redir_pc);
            check("fwd_wen", 32'(fwd_wen), 32'(em_valid && em_reg_wen && !em_mem_ren));
            check("load_pending", 32'(load_pending), 32'(em_valid && em_mem_ren));
            if (em_valid) begin
                check("m_pc", bus.m_pc, em_pc);
                check("m_result", bus.m_result, em_result);
                check("m_store_data", bus.m_store_data, em_store);
                check("m_rd", 32'(bus.m_rd), 32'(em_rd));
                check("m_ctrl", {28'd0, bus.m_reg_wen, bus.m_mem_ren, bus.m_mem_wen, 1'b0},
                      {28'd0, em_reg_wen, em_mem_ren, em_mem_wen, 1'b0});
                check("m_reg_wsel", 32'(bus.m_reg_wsel), 32'(em_wsel));
                check("m_mem_type", 32'(bus.m_mem_type), 32'(em_mem_type));
                check("fwd_rd", 32'(fwd_rd), 32'(em_rd));
                check("fwd_value", fwd_value, em_result);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.x_valid = 0; bus.x_pc = 0; bus.x_imm = 0; bus.x_rs1 = 0; bus.x_rs2 = 0;
        bus.x_csr_value = 0; bus.x_rd = 0; bus.x_reg_wen = 0; bus.x_reg_wsel = WSEL_ALU;
        bus.x_aluop = ALU_ADD; bus.x_asel = 0; bus.x_bsel = 0; bus.x_mem_type = 0;
        bus.x_mem_ren = 0; bus.x_mem_wen = 0; bus.x_is_jump = 0; bus.x_is_branch = 0;
        bus.x_branch_cond = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input aluop_t op, input logic asel, input logic bsel,
                         input wsel_t ws, input logic wen, input regaddr_t rd);
        idle();
        bus.x_valid = 1; bus.x_pc = pc; bus.x_rs1 = rs1; bus.x_rs2 = rs2; bus.x_imm = imm;
        bus.x_aluop = op; bus.x_asel = asel; bus.x_bsel = bsel; bus.x_reg_wsel = ws;
        bus.x_reg_wen = wen; bus.x_rd = rd;
    endtask

    aluop_t      t_op  [9];
    logic [31:0] t_a   [9];
    logic [31:0] t_b   [9];
    logic [31:0] t_exp [9];
    logic [2:0]  b_cond [5];
    logic        b_exp  [5];

    initial begin
        t_op  = '{ALU_SUB, ALU_SLL, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_OR, ALU_AND, ALU_PASSB};
        t_a   = '{32'd5, 32'd1, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'h0000_F0F0, 32'h0000_FF00, 32'd0};
        t_b   = '{32'd7, 32'd31, 32'h21, 32'd4, 32'd1, 32'd1, 32'h0000_0F0F, 32'h0000_0FF0, 32'h1234};
        t_exp = '{32'hFFFF_FFFE, 32'h8000_0000, 32'd2, 32'h0800_0000, 32'd1, 32'd0,
                  32'h0000_FFFF, 32'h0000_0F00, 32'h1234};
        b_cond = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
        b_exp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        idle();
        bus.m_ready = 0;
        tick();
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, RESET_PC);
        check("rst_m_result", bus.m_result, 32'd0);
        check("rst_m_pc", bus.m_pc, 32'd0);
        rst_n = 1;
        bus.m_ready = 1;

        // ADD rs1 + imm
        drive(32'h0, 32'd5, 32'd0, 32'd7, ALU_ADD, 0, 1, WSEL_ALU, 1, 5'd1);
        tick();
        check("add_m_valid", 32'(bus.m_valid), 32'd1);
        check("add_m_result", bus.m_result, 32'd12);
        check("add_fwd_wen", 32'(fwd_wen), 32'd1);
        check("add_fwd_value", fwd_value, 32'd12);

        // taken BEQ followed by one wrong-path instruction
        drive(32'h100, 32'd3, 32'd3, 32'h20, ALU_ADD, 1, 1, WSEL_ALU, 0, 5'd0);
        bus.x_is_branch = 1; bus.x_branch_cond = BR_EQ;
        tick();
        check("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h120);
        check("beq_m_reg_wen", 32'(bus.m_reg_wen), 32'd0);
        drive(32'h104, 32'd1, 32'd0, 32'd1, ALU_ADD, 0, 1, WSEL_ALU, 1, 5'd2);
        #1;
        check("shadow_x_ready", 32'(bus.x_ready), 32'd1);
        tick();
        check("shadow_redirect_end", 32'(redirect_valid), 32'd0);
        check("shadow_dropped", 32'(bus.m_valid), 32'd0);
        idle();
        tick();
        check("no_second_redirect", 32'(redirect_valid), 32'd0);

        // BNE with equal operands: not taken, but still occupies m
        drive(32'h200, 32'd9, 32'd9, 32'h40, ALU_ADD, 1, 1, WSEL_ALU, 0, 5'd0);
        bus.x_is_branch = 1; bus.x_branch_cond = BR_NE;
        tick();
        check("bne_redirect", 32'(redirect_valid), 32'd0);
        check("bne_m_valid", 32'(bus.m_valid), 32'd1);
        check("bne_m_reg_wen", 32'(bus.m_reg_wen), 32'd0);

        // JALR clears bit 0, writes pc+4
        drive(32'h40, 32'h203, 32'd0, 32'd0, ALU_ADD, 0, 1, WSEL_PC4, 1, 5'd1);
        bus.x_is_jump = 1;
        tick();
        check("jalr_redirect_valid", 32'(redirect_valid), 32'd1);
        check("jalr_redirect_pc", redirect_pc, 32'h202);
        check("jalr_m_result", bus.m_result, 32'h44);
        idle();
        tick();

        // backpressure hold and same-edge replace
        bus.m_ready = 0;
        drive(32'h10, 32'd1, 32'd0, 32'd2, ALU_ADD, 0, 1, WSEL_ALU, 1, 5'd3);
        tick();
        check("bp_first", bus.m_result, 32'd3);
        drive(32'h14, 32'hF0, 32'hFF, 32'd0, ALU_XOR, 0, 0, WSEL_ALU, 1, 5'd4);
        #1;
        check("bp_x_ready", 32'(bus.x_ready), 32'd0);
        tick();
        check("bp_hold", bus.m_result, 32'd3);
        bus.m_ready = 1;
        tick();
        check("bp_replace", bus.m_result, 32'h0F);

        // taken branch held by backpressure redirects only once it fires
        bus.m_ready = 0;
        drive(32'h300, 32'd0, 32'd0, 32'd8, ALU_ADD, 1, 1, WSEL_ALU, 0, 5'd0);
        bus.x_is_branch = 1; bus.x_branch_cond = BR_EQ;
        tick();
        check("held_br_no_redirect", 32'(redirect_valid), 32'd0);
        check("held_br_m_hold", bus.m_result, 32'h0F);
        bus.m_ready = 1;
        tick();
        check("held_br_redirect", 32'(redirect_valid), 32'd1);
        check("held_br_pc", redirect_pc, 32'h308);
        idle();
        tick();

        // LW and SW
        drive(32'h20, 32'h1000, 32'd0, 32'd4, ALU_ADD, 0, 1, WSEL_MEM, 1, 5'd5);
        bus.x_mem_ren = 1; bus.x_mem_type = 3'b010;
        tick();
        check("lw_load_pending", 32'(load_pending), 32'd1);
        check("lw_fwd_wen", 32'(fwd_wen), 32'd0);
        check("lw_addr", bus.m_result, 32'h1004);
        drive(32'h24, 32'h2000, 32'hDEAD_BEEF, 32'd8, ALU_ADD, 0, 1, WSEL_ALU, 0, 5'd0);
        bus.x_mem_wen = 1; bus.x_mem_type = 3'b010;
        tick();
        check("sw_data", bus.m_store_data, 32'hDEAD_BEEF);
        check("sw_addr", bus.m_result, 32'h2008);

        // SRA, op table, CSR select
        drive(32'h28, 32'h8000_0000, 32'd4, 32'd0, ALU_SRA, 0, 0, WSEL_ALU, 1, 5'd6);
        tick();
        check("sra", bus.m_result, 32'hF800_0000);
        for (int i = 0; i < 9; i++) begin
            drive(32'h30, t_a[i], t_b[i], 32'd0, t_op[i], 0, 0, WSEL_ALU, 1, 5'(i + 7));
            tick();
            check("op_table", bus.m_result, t_exp[i]);
        end
        drive(32'h34, 32'd1, 32'd2, 32'd0, ALU_ADD, 0, 0, WSEL_CSR, 1, 5'd20);
        bus.x_csr_value = 32'hABCD;
        tick();
        check("csr_sel", bus.m_result, 32'hABCD);

        // branch condition encodings with rs1=-1, rs2=1
        for (int i = 0; i < 5; i++) begin
            drive(32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, ALU_ADD, 1, 1, WSEL_ALU, 0, 5'd0);
            bus.x_is_branch = 1; bus.x_branch_cond = b_cond[i];
            tick();
            check("br_cond", 32'(redirect_valid), 32'(b_exp[i]));
            idle();
            tick();
        end

        // reset while in SHADOW
        drive(32'h80, 32'd0, 32'd0, 32'h10, ALU_ADD, 1, 1, WSEL_PC4, 1, 5'd1);
        bus.x_is_jump = 1;
        tick();
        check("jal_redirect_pc", redirect_pc, 32'h90);
        idle();
        #1;
        rst_n = 0;
        #1;
        check("rst_shadow_redirect", 32'(redirect_valid), 32'd0);
        check("rst_shadow_pc", redirect_pc, RESET_PC);
        check("rst_shadow_m_valid", 32'(bus.m_valid), 32'd0);
        tick();
        rst_n = 1;
        drive(32'h0, 32'd40, 32'd0, 32'd2, ALU_ADD, 0, 1, WSEL_ALU, 1, 5'd2);
        tick();
        check("post_rst_add", bus.m_result, 32'd42);
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_execute.md
Name: core_execute

Overview:
- Execute stage of the in-order RV32I pipeline. It is the consumer end of the decode-to-execute bundle and sits between the decode pipeline register and the memory stage.
- Performs ALU ops, resolves branches and jumps, and registers results into the execute-to-memory bundle under a valid/ready handshake.
- Issues a registered control-flow redirect. It then discards the single wrong-path instruction that decode has already launched.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, redirect_pc value held in reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- x_valid  in  1  decode bundle valid
- x_ready  out  1  execute accepts bundle this cycle
- x_pc, x_imm, x_rs1, x_rs2, x_csr_value  in  XLEN each  operands (already forwarded)
- x_rd  in  rv::regaddr_t  destination register
- x_reg_wen  in  1  register write enable
- x_reg_wsel  in  rv::wsel_t  writeback source: ALU/MEM/PC4/CSR
- x_aluop  in  rv::aluop_t  ALU operation
- x_asel  in  1  ALU operand A: 0=rs1, 1=pc
- x_bsel  in  1  ALU operand B: 0=rs2, 1=imm
- x_mem_type  in  3  funct3 of load/store
- x_mem_ren, x_mem_wen  in  1 each  load / store
- x_is_jump, x_is_branch  in  1 each  control-flow class
- x_branch_cond  in  3  branch funct3
- m_valid  out  1  memory bundle valid
- m_ready  in  1  memory stage accepts
- m_pc, m_result, m_store_data  out  XLEN each  registered pc, result/address, rs2
- m_rd  out  rv::regaddr_t  registered rd
- m_reg_wen, m_mem_ren, m_mem_wen  out  1 each  registered controls
- m_reg_wsel  out  rv::wsel_t  registered writeback source
- m_mem_type  out  3  registered memory type
- redirect_valid  out  1  flush fetch/decode, load redirect_pc
- redirect_pc  out  XLEN  target
- fwd_rd  out  rv::regaddr_t  forwarding destination (=m_rd)
- fwd_wen  out  1  m_valid & m_reg_wen & ~m_mem_ren
- fwd_value  out  XLEN  =m_result
- load_pending  out  1  m_valid & m_mem_ren (decode uses this for load-use stall)

Behaviour:
- Reset values: m_valid=0, redirect_valid=0, redirect_pc=RESET_PC, all other m_* = 0.
- ALU operand A = asel ? pc : rs1; operand B = bsel ? imm : rs2.
- ALU ops: ADD, SUB, SLL, SRL, SRA (shift amount B[4:0]), SLT, SLTU, XOR, OR, AND, PASSB.
- Result select: PC4 → pc+4; CSR → csr_value; ALU/MEM → ALU output. For MEM, the ALU output is the effective address.
- Branch compare on rs1/rs2 by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Other encodings are never taken.
- Targets: branch target = pc+imm. Jump target = ALU sum with bit0 cleared, which covers both JAL and JALR. Misaligned targets are not trapped.
- taken = is_jump | (is_branch & cond_true).
- fire = x_valid & x_ready.
- x_ready = shadow | ~m_valid | m_ready.
- State machine, two states:
  - NORMAL, where shadow=0.
  - SHADOW, where shadow=1; it is defined as redirect_valid=1.
  - NORMAL→SHADOW: fire & taken. The next cycle has redirect_valid=1 and redirect_pc=target.
  - SHADOW→NORMAL: unconditionally after one cycle.
  - redirect_valid is a single-cycle pulse.
  - In SHADOW, x_ready=1 and any x_valid instruction is consumed and dropped. It never loads m_*, never redirects, and has no effect on forwarding.
- m register:
  - On fire & ~shadow: load all m_* fields and set m_valid=1. A taken branch also loads m_* with m_reg_wen=0 (x_reg_wen=0 from decode).
  - Else if m_ready: m_valid=0.
  - Else: hold.
- Simultaneous m_ready and new fire: new data replaces the old in the same edge, with no bubble.
- Latency: 1 cycle x→m; redirect 1 cycle after the branch fires.
- A branch held by m backpressure (x_valid=1, x_ready=0) produces no redirect until it fires.
- Async reset mid-SHADOW returns to NORMAL with no redirect.

Decomposition:
- rv package holds: aluop_t enum, wsel_t enum, regaddr_t, branch funct3 constants, XLEN default.
- Sub-module core_alu: combinational; ops, operands → result, sum; branch comparator included.
- Handshake, shadow FSM and m register stay in core_execute.

Test Plan:
- ADD rs1=5, imm=7, bsel=1, x_valid=1, m_ready=1 → next cycle m_valid=1, m_result=12, fwd_wen=1, fwd_value=12.
- BEQ pc=0x100, rs1=rs2=3, imm=0x20; next cycle x_valid=1 (wrong path) → redirect_valid=1 and redirect_pc=0x120 for exactly one cycle; the wrong-path instruction is dropped (m_valid=0 the cycle after its m_ready drains); no second redirect.
- BNE with rs1=rs2 → no redirect; m_valid=1, m_reg_wen=0.
- JALR rs1=0x203, imm=0, asel=0, wsel=PC4, pc=0x40 → redirect_pc=0x202, m_result=0x44.
- m_ready=0 with m_valid=1 and new x_valid=1 → x_ready=0, m_* held; release m_ready → instruction accepted and loaded the same edge.
- LW fire → load_pending=1, fwd_wen=0. SRA rs1=0x8000_0000, rs2=4 → m_result=0xF800_0000. rst_n low during SHADOW → redirect_valid=0, redirect_pc=RESET_PC.
